// File: rtl/conv_frame_streamer_if.sv
// AXI-Stream link between the frame streamer and the convolution slave port.
interface conv_frame_streamer_if #(
  parameter int C_AXIS_TDATA_WIDTH = 32
);
  logic [C_AXIS_TDATA_WIDTH-1:0] tdata;
  logic                          tvalid;
  logic                          tready;
  logic                          tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/conv_frame_streamer.sv
// Streams an 8-bit image from a pixel memory as 3-pixel window columns,
// framed by a start marker and a two-word end marker carrying tlast.
module conv_frame_streamer #(
  parameter int ADDR_WIDTH         = 12,
  parameter int C_AXIS_TDATA_WIDTH = 32,
  parameter int PIXEL_NB           = 8,
  parameter int IMG_W              = 64,
  parameter int IMG_H              = 64,
  parameter int KERNEL_SIZE        = 3
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_NB-1:0]   mem_rdata,
  conv_frame_streamer_if.master m00_axis
);
    localparam logic [ADDR_WIDTH-1:0] IMG_W_A  = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] K_LAST   = ADDR_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(IMG_H - 3);

    typedef enum logic [2:0] {S_IDLE, S_SOF, S_PIX, S_EOF0, S_EOF1} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] k, col, row;
    logic [ADDR_WIDTH-1:0] k_nx, col_nx, row_nx, rd_addr;
    logic                  last_rd, reads_done;
    logic [PIXEL_NB-1:0]   skid;
    logic                  skid_valid;
    logic                  pop, load, can_issue;
    logic [1:0]            occ;

    always_comb begin
        rd_addr = (row + k) * IMG_W_A + col;
        last_rd = (row == ROW_LAST) && (col == COL_LAST) && (k == K_LAST);
        k_nx    = k + 1'b1;
        col_nx  = col;
        row_nx  = row;
        if (k == K_LAST) begin
            k_nx   = '0;
            col_nx = col + 1'b1;
            if (col == COL_LAST) begin
                col_nx = '0;
                row_nx = (row == ROW_LAST) ? '0 : row + 1'b1;
            end
        end
        pop  = m00_axis.tvalid & m00_axis.tready;
        load = ~m00_axis.tvalid | pop;
        // Slots held after this edge: output beat + skid entry + read landing now, minus the beat leaving.
        occ = {1'b0, m00_axis.tvalid} + {1'b0, skid_valid} + {1'b0, mem_rd_en} - {1'b0, pop};
        can_issue = ~reads_done && (occ < 2'd2);
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            state           <= S_IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_rd_en       <= 1'b0;
            mem_addr        <= '0;
            k               <= '0;
            col             <= '0;
            row             <= '0;
            reads_done      <= 1'b0;
            skid            <= '0;
            skid_valid      <= 1'b0;
            m00_axis.tdata  <= '0;
            m00_axis.tvalid <= 1'b0;
            m00_axis.tlast  <= 1'b0;
        end else begin
            done      <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    state           <= S_SOF;
                    busy            <= 1'b1;
                    m00_axis.tvalid <= 1'b1;
                    m00_axis.tlast  <= 1'b0;
                    m00_axis.tdata  <= C_AXIS_TDATA_WIDTH'(123);
                    mem_rd_en       <= 1'b1;
                    mem_addr        <= rd_addr;
                    k               <= k_nx;
                    col             <= col_nx;
                    row             <= row_nx;
                    reads_done      <= last_rd;
                    skid_valid      <= 1'b0;
                end
                S_SOF, S_PIX: begin
                    if (can_issue) begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= rd_addr;
                        k         <= k_nx;
                        col       <= col_nx;
                        row       <= row_nx;
                        if (last_rd) reads_done <= 1'b1;
                    end
                    if (load) begin
                        if (state == S_SOF) state <= S_PIX;
                        if (skid_valid) begin
                            m00_axis.tdata  <= C_AXIS_TDATA_WIDTH'(skid);
                            m00_axis.tvalid <= 1'b1;
                            skid_valid      <= mem_rd_en;
                            skid            <= mem_rdata;
                        end else if (mem_rd_en) begin
                            m00_axis.tdata  <= C_AXIS_TDATA_WIDTH'(mem_rdata);
                            m00_axis.tvalid <= 1'b1;
                        end else if (reads_done && state == S_PIX) begin
                            m00_axis.tdata  <= C_AXIS_TDATA_WIDTH'(124);
                            m00_axis.tvalid <= 1'b1;
                            state           <= S_EOF0;
                        end else begin
                            m00_axis.tvalid <= 1'b0;
                        end
                    end else if (mem_rd_en) begin
                        skid       <= mem_rdata;
                        skid_valid <= 1'b1;
                    end
                end
                S_EOF0: if (pop) begin
                    m00_axis.tdata <= C_AXIS_TDATA_WIDTH'(79);
                    m00_axis.tlast <= 1'b1;
                    state          <= S_EOF1;
                end
                S_EOF1: if (pop) begin
                    m00_axis.tvalid <= 1'b0;
                    m00_axis.tlast  <= 1'b0;
                    busy            <= 1'b0;
                    done            <= 1'b1;
                    state           <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_frame_streamer.sv
// Self-checking bench: two streamer instances (4x3 and 2x4 images) checked
// against a table of literal expected streams through a scoreboard queue.
module tb_conv_frame_streamer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start0, start1, rdy;
    logic        busy0, done0, rd0, busy1, done1, rd1;
    logic [11:0] addr0, addr1;
    logic [7:0]  rdata0, rdata1;
    logic [7:0]  mem [0:4095];

    // Pixel memory: registered address from the DUT, data captured at the next edge.
    assign rdata0 = mem[addr0];
    assign rdata1 = mem[addr1];

    conv_frame_streamer_if #(.C_AXIS_TDATA_WIDTH(32)) s0 ();
    conv_frame_streamer_if #(.C_AXIS_TDATA_WIDTH(32)) s1 ();
    assign s0.tready = rdy;
    assign s1.tready = rdy;

    conv_frame_streamer #(.ADDR_WIDTH(12), .C_AXIS_TDATA_WIDTH(32), .PIXEL_NB(8),
                          .IMG_W(4), .IMG_H(3), .KERNEL_SIZE(3)) dut0 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start0),
        .busy(busy0), .done(done0), .mem_rd_en(rd0), .mem_addr(addr0),
        .mem_rdata(rdata0), .m00_axis(s0));

    conv_frame_streamer #(.ADDR_WIDTH(12), .C_AXIS_TDATA_WIDTH(32), .PIXEL_NB(8),
                          .IMG_W(2), .IMG_H(4), .KERNEL_SIZE(3)) dut1 (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start1),
        .busy(busy1), .done(done1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rdata(rdata1), .m00_axis(s1));

    int          sel;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tlast, m_busy, m_done, m_rd;
    logic [11:0] m_addr;
    assign m_tdata  = (sel == 1) ? s1.tdata  : s0.tdata;
    assign m_tvalid = (sel == 1) ? s1.tvalid : s0.tvalid;
    assign m_tlast  = (sel == 1) ? s1.tlast  : s0.tlast;
    assign m_busy   = (sel == 1) ? busy1 : busy0;
    assign m_done   = (sel == 1) ? done1 : done0;
    assign m_rd     = (sel == 1) ? rd1   : rd0;
    assign m_addr   = (sel == 1) ? addr1 : addr0;

    typedef struct {
        int       sel;
        int       mem_mode;
        bit [3:0] pat;
        bit       restart;
        int       exp [15];
    } vec_t;

    vec_t vecs [5];
    int   checks, failures;
    int   q [$];

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic set_mem(input int mode);
        for (int i = 0; i < 4096; i++)
            case (mode)
                0:       mem[i] = 8'(i);
                1:       mem[i] = 8'(i + 10);
                default: mem[i] = 8'hFF;
            endcase
    endtask

    task automatic set_start(input int s, input logic val);
        if (s == 1) start1 = val; else start0 = val;
    endtask

    task automatic run_frame(input int v, input bit do_start, input bit chain_next);
        int          cycles = 0, stalls = 0, exp_v;
        bit          got_done = 0, prev_stall = 0;
        logic [31:0] prev_data = '0;
        sel = vecs[v].sel;
        foreach (vecs[v].exp[i]) q.push_back(vecs[v].exp[i]);
        if (do_start) begin
            @(negedge clk);
            rdy = 1'b1;
            set_start(sel, 1'b1);
        end
        while (!got_done && cycles < 400) begin
            @(negedge clk);
            cycles++;
            if (cycles == 1) begin
                set_start(sel, 1'b0);
                chk("first_busy", m_busy, 1);
                chk("first_tvalid", m_tvalid, 1);
                chk("first_rd_en", m_rd, 1);
                chk("first_addr", m_addr, 0);
            end
            if (vecs[v].restart && cycles == 3) set_start(sel, 1'b1);
            if (vecs[v].restart && cycles == 4) set_start(sel, 1'b0);
            rdy = vecs[v].pat[(cycles - 1) % 4];
            if (prev_stall) chk("stall_hold", m_tdata, prev_data);
            prev_stall = 0;
            if (m_done) begin
                got_done = 1;
                chk("done_latency", cycles, 16 + stalls);
                chk("busy_at_done", m_busy, 0);
                chk("beats_left", q.size(), 0);
                chk("tvalid_at_done", m_tvalid, 0);
            end else if (m_tvalid) begin
                if (rdy) begin
                    if (q.size() == 0) begin
                        chk("extra_beat", m_tdata, -1);
                    end else begin
                        exp_v = q.pop_front();
                        chk("beat", m_tdata, exp_v);
                        chk("tlast", m_tlast, (q.size() == 0) ? 1 : 0);
                    end
                end else begin
                    stalls++;
                    prev_stall = 1;
                    prev_data  = m_tdata;
                end
            end
        end
        if (!got_done) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout vec=%0d got=no_done exp=done", v);
        end
        q.delete();
        if (chain_next) begin
            set_start(sel, 1'b1);
        end else begin
            repeat (5) begin
                @(negedge clk);
                chk("no_second_done", m_done, 0);
            end
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; start0 = 1'b0; start1 = 1'b0; rdy = 1'b1; sel = 0;

        vecs[0] = '{sel: 0, mem_mode: 0, pat: 4'b1111, restart: 0,
                    exp: '{123, 0, 4, 8, 1, 5, 9, 2, 6, 10, 3, 7, 11, 124, 79}};
        vecs[1] = vecs[0];
        vecs[1].pat = 4'b1001;
        vecs[2] = '{sel: 1, mem_mode: 1, pat: 4'b1111, restart: 0,
                    exp: '{123, 10, 12, 14, 11, 13, 15, 12, 14, 16, 13, 15, 17, 124, 79}};
        vecs[3] = vecs[0];
        vecs[3].restart = 1;
        vecs[4] = vecs[0];
        vecs[4].mem_mode = 2;
        vecs[4].pat = 4'b0101;
        for (int i = 1; i <= 12; i++) vecs[4].exp[i] = 255;

        set_mem(0);
        repeat (3) @(negedge clk);
        chk("rst_tvalid", s0.tvalid, 0);
        chk("rst_tlast", s0.tlast, 0);
        chk("rst_tdata", s0.tdata, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rd_en", rd0, 0);
        chk("rst_addr", addr0, 0);
        chk("rst_tvalid1", s1.tvalid, 0);
        rst_n = 1'b1;

        for (int v = 0; v < 5; v++) begin
            set_mem(vecs[v].mem_mode);
            run_frame(v, 1'b1, 1'b0);
        end

        // start in the same cycle as done: the next frame follows immediately
        set_mem(0);
        run_frame(0, 1'b1, 1'b1);
        run_frame(0, 1'b0, 1'b0);

        // asynchronous reset while the 7th beat is on the bus
        sel = 0;
        rdy = 1'b1;
        @(negedge clk) start0 = 1'b1;
        @(negedge clk) start0 = 1'b0;
        repeat (6) @(negedge clk);
        chk("pre_reset_tvalid", s0.tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_tvalid", s0.tvalid, 0);
        chk("async_rst_busy", busy0, 0);
        chk("async_rst_rd_en", rd0, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_after_rst_tvalid", s0.tvalid, 0);
            chk("idle_after_rst_busy", busy0, 0);
        end
        run_frame(0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
